// File: rtl/cajero_param_pkg.sv
// Shared state encoding and transaction/card constants for the cajero_param ATM controller.
package cajero_param_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PIN_ENTRY,
        PIN_CHECK,
        WAIT_MONTO,
        DEPOSIT,
        WITHDRAW,
        LOCKED
    } state_t;

    localparam logic TRANS_DEPOSITO  = 1'b0;
    localparam logic TRANS_RETIRO    = 1'b1;
    localparam logic CARD_LOCAL      = 1'b0;
    localparam logic CARD_EXTRANJERA = 1'b1;

endpackage

// File: rtl/cajero_param_pin_entry.sv
// Serial PIN collector: edge-detects the digit strobe, shifts digits in at the LS end,
// flags the final digit and compares the assembled entry against the stored PIN.
module cajero_param_pin_entry #(
    parameter int PIN_DIGITS = 4,
    parameter int DIGIT_W    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          enable,
    input  logic [PIN_DIGITS*DIGIT_W-1:0] pin,
    input  logic [DIGIT_W-1:0]            digito,
    input  logic                          digito_stb,
    output logic                          done,
    output logic                          match
);

    localparam int PIN_W = PIN_DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIN_DIGITS - 1);

    logic             stb_prev;
    logic [CNT_W-1:0] count;
    logic [PIN_W-1:0] shreg;
    logic             take;

    assign take  = enable & digito_stb & ~stb_prev;
    assign done  = take & (count == LAST);
    assign match = (shreg == pin);

    always_ff @(posedge clk) begin
        if (!reset) begin
            stb_prev <= 1'b0;
            count    <= '0;
        end else begin
            stb_prev <= digito_stb;
            if (clear)
                count <= '0;
            else if (take)
                count <= done ? '0 : count + 1'b1;
        end
    end

    // The shift register is cleared whenever a fresh entry starts, so it needs no reset.
    always_ff @(posedge clk) begin
        if (clear)
            shreg <= '0;
        else if (take)
            shreg <= (shreg << DIGIT_W) | PIN_W'(digito);
    end

endmodule

// File: rtl/cajero_param.sv
// Parametrised ATM transaction controller: PIN authentication, deposits/withdrawals, lockout.
// Optional foreign-card withdrawal fee enabled by defining CAJERO_FOREIGN_FEE_EN.
module cajero_param
    import cajero_param_pkg::*;
#(
    parameter int              PIN_DIGITS   = 4,
    parameter int              DIGIT_W      = 4,
    parameter int              AMOUNT_W     = 32,
    parameter int              BALANCE_W    = 64,
    parameter int              MAX_TRIES    = 3,
    parameter longint unsigned INIT_BALANCE = 50000,
    parameter int              FOREIGN_FEE  = 25
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tarjeta_recibida,
    input  logic                          tipo_de_tarjeta,
    input  logic [PIN_DIGITS*DIGIT_W-1:0] pin,
    input  logic [DIGIT_W-1:0]            digito,
    input  logic                          digito_stb,
    input  logic                          tipo_trans,
    input  logic [AMOUNT_W-1:0]           monto,
    input  logic                          monto_stb,
    output logic [BALANCE_W-1:0]          balance,
    output logic                          balance_actualizado,
    output logic                          entregar_dinero,
    output logic                          fondos_insuficientes,
    output logic                          pin_incorrecto,
    output logic                          advertencia,
    output logic                          bloqueo
);

    localparam int CNT_W = $clog2(MAX_TRIES + 1);

    state_t                 state, state_next;
    logic [CNT_W-1:0]       fails, fails_next, fails_inc;
    logic [BALANCE_W-1:0]   balance_next;
    logic                   ba_next, ed_next, fi_next, pi_next;
    logic                   monto_prev, monto_edge, capture;
    logic [AMOUNT_W-1:0]    monto_q;
    logic [BALANCE_W:0]     fee, debit;
    logic                   pin_done, pin_match;

    function automatic logic [BALANCE_W-1:0] sat_add(input logic [BALANCE_W-1:0] a,
                                                     input logic [AMOUNT_W-1:0]  b);
        logic [BALANCE_W:0] sum;
        sum = {1'b0, a} + {{(BALANCE_W + 1 - AMOUNT_W){1'b0}}, b};
        return sum[BALANCE_W] ? '1 : sum[BALANCE_W-1:0];
    endfunction

    cajero_param_pin_entry #(
        .PIN_DIGITS (PIN_DIGITS),
        .DIGIT_W    (DIGIT_W)
    ) u_pin_entry (
        .clk        (clk),
        .reset      (reset),
        .clear      ((state == IDLE) || (state == PIN_CHECK)),
        .enable     ((state == PIN_ENTRY) && tarjeta_recibida),
        .pin        (pin),
        .digito     (digito),
        .digito_stb (digito_stb),
        .done       (pin_done),
        .match      (pin_match)
    );

`ifdef CAJERO_FOREIGN_FEE_EN
    logic card_q;
    always_ff @(posedge clk) begin
        if (capture)
            card_q <= tipo_de_tarjeta;
    end
    assign fee = (card_q == CARD_EXTRANJERA) ? (BALANCE_W + 1)'(FOREIGN_FEE) : '0;
`else
    logic unused_fee_cfg;
    assign unused_fee_cfg = ^{tipo_de_tarjeta, 32'(FOREIGN_FEE)};
    assign fee = '0;
`endif

    // Debit is formed one bit wider than the balance so monto+fee never wraps.
    assign debit      = {{(BALANCE_W + 1 - AMOUNT_W){1'b0}}, monto_q} + fee;
    assign monto_edge = monto_stb & ~monto_prev;
    assign fails_inc  = fails + 1'b1;

    always_comb begin
        state_next   = state;
        fails_next   = fails;
        balance_next = balance;
        ba_next      = 1'b0;
        ed_next      = 1'b0;
        fi_next      = 1'b0;
        pi_next      = 1'b0;
        capture      = 1'b0;
        if (state != LOCKED && !tarjeta_recibida) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:       state_next = PIN_ENTRY;
                PIN_ENTRY:  if (pin_done) state_next = PIN_CHECK;
                PIN_CHECK: begin
                    if (pin_match) begin
                        state_next = WAIT_MONTO;
                        fails_next = '0;
                    end else begin
                        pi_next    = 1'b1;
                        fails_next = fails_inc;
                        state_next = (fails_inc == CNT_W'(MAX_TRIES)) ? LOCKED : PIN_ENTRY;
                    end
                end
                WAIT_MONTO: begin
                    if (monto_edge) begin
                        capture    = 1'b1;
                        state_next = (tipo_trans == TRANS_RETIRO) ? WITHDRAW : DEPOSIT;
                    end
                end
                DEPOSIT: begin
                    balance_next = sat_add(balance, monto_q);
                    ba_next      = 1'b1;
                    state_next   = WAIT_MONTO;
                end
                WITHDRAW: begin
                    if (debit <= {1'b0, balance}) begin
                        balance_next = balance - debit[BALANCE_W-1:0];
                        ba_next      = 1'b1;
                        ed_next      = 1'b1;
                    end else begin
                        fi_next = 1'b1;
                    end
                    state_next = WAIT_MONTO;
                end
                LOCKED:     state_next = LOCKED;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state                <= IDLE;
            fails                <= '0;
            balance              <= BALANCE_W'(INIT_BALANCE);
            monto_prev           <= 1'b0;
            balance_actualizado  <= 1'b0;
            entregar_dinero      <= 1'b0;
            fondos_insuficientes <= 1'b0;
            pin_incorrecto       <= 1'b0;
        end else begin
            state                <= state_next;
            fails                <= fails_next;
            balance              <= balance_next;
            monto_prev           <= monto_stb;
            balance_actualizado  <= ba_next;
            entregar_dinero      <= ed_next;
            fondos_insuficientes <= fi_next;
            pin_incorrecto       <= pi_next;
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            monto_q <= monto;
    end

    assign advertencia = (fails == CNT_W'(MAX_TRIES - 1)) && (state != LOCKED);
    assign bloqueo     = (state == LOCKED);

endmodule

// File: tb/tb_cajero_param.sv
// Scoreboard bench for cajero_param: directed sessions push expected pulse events, a monitor checks them.
`timescale 1ns/1ps
module tb_cajero_param;
    import cajero_param_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tarjeta_recibida = 1'b0;
    logic        tipo_de_tarjeta = 1'b0;
    logic [15:0] pin = 16'h3434;
    logic [3:0]  digito = '0;
    logic        digito_stb = 1'b0;
    logic        tipo_trans = 1'b0;
    logic [63:0] monto = '0;
    logic        monto_stb = 1'b0;
    logic [63:0] balance;
    logic        balance_actualizado, entregar_dinero, fondos_insuficientes, pin_incorrecto;
    logic        advertencia, bloqueo;

    typedef struct packed {
        logic [3:0]  pulses;
        logic [63:0] bal;
        logic        adv;
        logic        blk;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

`ifdef CAJERO_FOREIGN_FEE_EN
    localparam logic [63:0] EXP_FOREIGN = 64'd40875;
`else
    localparam logic [63:0] EXP_FOREIGN = 64'd40900;
`endif

    cajero_param #(
        .AMOUNT_W (64)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .tarjeta_recibida     (tarjeta_recibida),
        .tipo_de_tarjeta      (tipo_de_tarjeta),
        .pin                  (pin),
        .digito               (digito),
        .digito_stb           (digito_stb),
        .tipo_trans           (tipo_trans),
        .monto                (monto),
        .monto_stb            (monto_stb),
        .balance              (balance),
        .balance_actualizado  (balance_actualizado),
        .entregar_dinero      (entregar_dinero),
        .fondos_insuficientes (fondos_insuficientes),
        .pin_incorrecto       (pin_incorrecto),
        .advertencia          (advertencia),
        .bloqueo              (bloqueo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every cycle with a pulse consumes one expected event.
    always @(negedge clk) begin
        logic [3:0] p;
        exp_t       e;
        p = {balance_actualizado, entregar_dinero, fondos_insuficientes, pin_incorrecto};
        if (reset && p != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 64'(p), 64'd0);
            end else begin
                e = sb.pop_front();
                check("pulses",      64'(p),           64'(e.pulses));
                check("balance",     balance,          e.bal);
                check("advertencia", 64'(advertencia), 64'(e.adv));
                check("bloqueo",     64'(bloqueo),     64'(e.blk));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [3:0] p, input logic [63:0] b, input logic a, input logic k);
        exp_t e;
        e.pulses = p;
        e.bal    = b;
        e.adv    = a;
        e.blk    = k;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        digito_stb = 1'b0;
        monto_stb  = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_balance", balance, 64'd50000);
        check("rst_adv",     64'(advertencia), 64'd0);
        check("rst_bloqueo", 64'(bloqueo), 64'd0);
        check("rst_pulses",  64'({balance_actualizado, entregar_dinero,
                                  fondos_insuficientes, pin_incorrecto}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic enter_digit(input logic [3:0] d, input int hold);
        digito     = d;
        digito_stb = 1'b1;
        repeat (hold) tick();
        digito_stb = 1'b0;
        tick();
    endtask

    task automatic enter_pin(input logic [15:0] v, input int hold);
        for (int i = 3; i >= 0; i--) enter_digit(v[i*4 +: 4], hold);
        tick();
    endtask

    task automatic trans(input logic t, input logic [63:0] m, input int hold);
        tipo_trans = t;
        monto      = m;
        monto_stb  = 1'b1;
        repeat (hold) tick();
        monto_stb  = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        tipo_de_tarjeta  = CARD_LOCAL;
        tarjeta_recibida = 1'b1;

        // Deposit on a local card
        do_reset();
        enter_pin(16'h3434, 1);
        expect_ev(4'b1000, 64'd50100, 1'b0, 1'b0);
        trans(TRANS_DEPOSITO, 64'd100, 1);
        check("after_deposit", balance, 64'd50100);

        // Withdrawals: insufficient, normal, exact balance, from empty
        do_reset();
        enter_pin(16'h3434, 1);
        expect_ev(4'b0010, 64'd50000, 1'b0, 1'b0);
        trans(TRANS_RETIRO, 64'd1_000_000_000, 1);
        expect_ev(4'b1100, 64'd49900, 1'b0, 1'b0);
        trans(TRANS_RETIRO, 64'd100, 1);
        expect_ev(4'b1100, 64'd0, 1'b0, 1'b0);
        trans(TRANS_RETIRO, 64'd49900, 1);
        expect_ev(4'b0010, 64'd0, 1'b0, 1'b0);
        trans(TRANS_RETIRO, 64'd1, 1);

        // Three wrong PINs lead to lockout
        do_reset();
        expect_ev(4'b0001, 64'd50000, 1'b0, 1'b0);
        enter_pin(16'h1111, 1);
        check("adv_after_1", 64'(advertencia), 64'd0);
        expect_ev(4'b0001, 64'd50000, 1'b1, 1'b0);
        enter_pin(16'h2222, 1);
        check("adv_after_2", 64'(advertencia), 64'd1);
        expect_ev(4'b0001, 64'd50000, 1'b0, 1'b1);
        enter_pin(16'h0000, 1);
        check("bloqueo_after_3", 64'(bloqueo), 64'd1);
        enter_pin(16'h3434, 1);
        trans(TRANS_DEPOSITO, 64'd100, 1);
        check("locked_balance", balance, 64'd50000);
        tarjeta_recibida = 1'b0;
        repeat (2) tick();
        check("locked_after_removal", 64'(bloqueo), 64'd1);
        tarjeta_recibida = 1'b1;

        // Foreign card withdrawal
        tipo_de_tarjeta = CARD_EXTRANJERA;
        do_reset();
        enter_pin(16'h3434, 1);
        expect_ev(4'b1100, EXP_FOREIGN, 1'b0, 1'b0);
        trans(TRANS_RETIRO, 64'd9100, 1);
        tipo_de_tarjeta = CARD_LOCAL;

        // Card removed mid-PIN, then full entry and saturating deposits
        do_reset();
        enter_digit(4'h3, 1);
        enter_digit(4'h4, 1);
        tarjeta_recibida = 1'b0;
        repeat (2) tick();
        tarjeta_recibida = 1'b1;
        repeat (2) tick();
        enter_pin(16'h3434, 1);
        expect_ev(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        trans(TRANS_DEPOSITO, 64'hFFFF_FFFF_FFFF_FF9C, 1);
        expect_ev(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        trans(TRANS_DEPOSITO, 64'd1, 1);
        expect_ev(4'b1100, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0);
        trans(TRANS_RETIRO, 64'd5, 1);

        // Strobes held for several cycles count once
        do_reset();
        enter_pin(16'h3434, 3);
        expect_ev(4'b1000, 64'd50001, 1'b0, 1'b0);
        trans(TRANS_DEPOSITO, 64'd1, 3);
        expect_ev(4'b1000, 64'd50003, 1'b0, 1'b0);
        trans(TRANS_DEPOSITO, 64'd2, 1);

        // A correct entry clears the failure count
        do_reset();
        expect_ev(4'b0001, 64'd50000, 1'b0, 1'b0);
        enter_pin(16'h1111, 1);
        enter_pin(16'h3434, 1);
        expect_ev(4'b1000, 64'd50010, 1'b0, 1'b0);
        trans(TRANS_DEPOSITO, 64'd10, 1);
        tarjeta_recibida = 1'b0;
        repeat (2) tick();
        tarjeta_recibida = 1'b1;
        repeat (2) tick();
        expect_ev(4'b0001, 64'd50010, 1'b0, 1'b0);
        enter_pin(16'h9999, 1);
        check("adv_after_clear", 64'(advertencia), 64'd0);

        repeat (5) tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
